// File: rtl/branch_resolve_pkg.sv
// Shared control constants for the hmc-6502 branch resolver: state codes,
// state width and processor-status bit positions.
package branch_resolve_pkg;

    localparam int unsigned STATE_WIDTH = 8;

    localparam logic [STATE_WIDTH-1:0] BRANCH_TAKEN_STATE     = 8'd63;
    localparam logic [STATE_WIDTH-1:0] BRANCH_NOT_TAKEN_STATE = 8'd0;

    localparam int unsigned P_C = 0;
    localparam int unsigned P_Z = 1;
    localparam int unsigned P_I = 2;
    localparam int unsigned P_D = 3;
    localparam int unsigned P_B = 4;
    localparam int unsigned P_V = 6;
    localparam int unsigned P_N = 7;

endpackage

// File: rtl/branch_resolve_if.sv
// Decision inputs and combinational/registered results between the opcode
// decode side (master) and the branch resolver (slave).
interface branch_resolve_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] op_flags;
    logic             branch_polarity;
    logic             en;
    logic             branch_taken;
    logic [WIDTH-1:0] next_state_branch;
    logic             branch_taken_q;
    logic [WIDTH-1:0] next_state_branch_q;

    modport master (
        output p, op_flags, branch_polarity, en,
        input  branch_taken, next_state_branch, branch_taken_q, next_state_branch_q
    );

    modport slave (
        input  p, op_flags, branch_polarity, en,
        output branch_taken, next_state_branch, branch_taken_q, next_state_branch_q
    );
endinterface

// File: rtl/branchlogic.sv
// Branch decision: any masked status flag set, inverted by the opcode polarity.
module branchlogic #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] op_flags,
    input  logic             branch_polarity,
    output logic             branch_taken
);
    logic flag_hit;

    always_comb begin
        flag_hit     = |(p & op_flags);
        branch_taken = flag_hit ^ branch_polarity;
    end
endmodule

// File: rtl/latch.sv
// Enabled flop with asynchronous active-low reset to a parameterized value.
module latch #(
    parameter int unsigned           WIDTH       = 8,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end
endmodule

// File: rtl/mux2.sv
// Generic 2:1 multiplexer; s=1 selects d1.
module mux2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = s ? d1 : d0;
    end
endmodule

// File: rtl/branch_resolve.sv
// Branch resolver for the control FSM: picks the taken/not-taken next-state code
// from a masked status flag and offers it both combinationally and registered.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int unsigned      WIDTH           = STATE_WIDTH,
    parameter logic [WIDTH-1:0] TAKEN_STATE     = WIDTH'(BRANCH_TAKEN_STATE),
    parameter logic [WIDTH-1:0] NOT_TAKEN_STATE = WIDTH'(BRANCH_NOT_TAKEN_STATE)
) (
    input  logic               ph1,
    input  logic               reset,
    branch_resolve_if.slave    bus
);
    logic             taken;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH:0]   cap_d;
    logic [WIDTH:0]   cap_q;

    branchlogic #(.WIDTH(WIDTH)) u_branchlogic (
        .p               (bus.p),
        .op_flags        (bus.op_flags),
        .branch_polarity (bus.branch_polarity),
        .branch_taken    (taken)
    );

    mux2 #(.WIDTH(WIDTH)) u_mux2 (
        .d0 (NOT_TAKEN_STATE),
        .d1 (TAKEN_STATE),
        .s  (taken),
        .y  (next_state)
    );

    // Decision and state code are captured together so they never disagree.
    assign cap_d = {taken, next_state};

    latch #(
        .WIDTH       (WIDTH + 1),
        .RESET_VALUE ({1'b0, NOT_TAKEN_STATE})
    ) u_latch (
        .clk   (ph1),
        .reset (reset),
        .en    (bus.en),
        .d     (cap_d),
        .q     (cap_q)
    );

    assign bus.branch_taken        = taken;
    assign bus.next_state_branch   = next_state;
    assign bus.branch_taken_q      = cap_q[WIDTH];
    assign bus.next_state_branch_q = cap_q[WIDTH-1:0];
endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve with hand-computed expectations.
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    logic ph1;
    logic reset;
    int   checks;
    int   failures;

    branch_resolve_if #(.WIDTH(8)) bus ();

    branch_resolve #(.WIDTH(8)) dut (
        .ph1   (ph1),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] p, input logic [7:0] flags, input logic pol);
        bus.p               = p;
        bus.op_flags        = flags;
        bus.branch_polarity = pol;
    endtask

    task automatic check_comb(input string tag, input logic taken);
        #1;
        check({tag, "_taken"}, 32'(bus.branch_taken), 32'(taken));
        check({tag, "_state"}, 32'(bus.next_state_branch), taken ? 32'd63 : 32'd0);
    endtask

    task automatic check_q(input string tag, input logic taken);
        check({tag, "_taken_q"}, 32'(bus.branch_taken_q), 32'(taken));
        check({tag, "_state_q"}, 32'(bus.next_state_branch_q), taken ? 32'd63 : 32'd0);
    endtask

    task automatic edge_then_sample();
        @(posedge ph1);
        #1;
    endtask

    initial begin
        int bits [4];
        logic [7:0] pv;
        logic [7:0] mask;
        bits = '{P_C, P_Z, P_V, P_N};
        checks   = 0;
        failures = 0;

        reset = 1'b0;
        bus.en = 1'b0;
        drive(8'h00, 8'h00, 1'b0);
        #12;
        check_q("reset", 1'b0);

        @(negedge ph1);
        reset = 1'b1;

        // BEQ, Z set: combinational then registered after one enabled edge
        drive(8'h02, 8'h02, 1'b0);
        check_comb("beq_z1", 1'b1);
        bus.en = 1'b1;
        edge_then_sample();
        check_q("beq_cap", 1'b1);
        bus.en = 1'b0;

        drive(8'h00, 8'h02, 1'b0);
        check_comb("beq_z0", 1'b0);
        drive(8'h02, 8'h02, 1'b1);
        check_comb("bne_z1", 1'b0);
        drive(8'hFD, 8'h02, 1'b1);
        check_comb("bne_z0", 1'b1);

        for (int b = 0; b < 4; b++) begin
            for (int pol = 0; pol < 2; pol++) begin
                for (int pi = 0; pi < 2; pi++) begin
                    pv   = (pi == 1) ? 8'hFF : 8'h00;
                    mask = 8'h01 << bits[b];
                    drive(pv, mask, pol[0]);
                    // p is all-zeros or all-ones, so the selected flag equals pi
                    check_comb($sformatf("sweep_b%0d_pol%0d_p%0d", bits[b], pol, pi),
                               pi[0] ^ pol[0]);
                end
            end
        end

        drive(8'hFF, 8'h00, 1'b1);
        check_comb("nomask_pol1", 1'b1);
        drive(8'hFF, 8'h00, 1'b0);
        check_comb("nomask_pol0", 1'b0);
        drive(8'h40, 8'hC0, 1'b0);
        check_comb("multi_mask", 1'b1);
        drive(8'h20, 8'h00, 1'b0);
        check_comb("bit5_unmasked", 1'b0);
        drive(8'h20, 8'h20, 1'b0);
        check_comb("bit5_masked", 1'b1);

        // Enable hold
        @(negedge ph1);
        drive(8'h02, 8'h02, 1'b0);
        bus.en = 1'b1;
        edge_then_sample();
        check_q("hold_cap", 1'b1);
        drive(8'h00, 8'h02, 1'b0);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_then_sample();
            check_q($sformatf("hold_%0d", i), 1'b1);
        end
        bus.en = 1'b1;
        edge_then_sample();
        check_q("hold_release", 1'b0);

        // Asynchronous reset mid-cycle
        drive(8'h02, 8'h02, 1'b0);
        edge_then_sample();
        check_q("rst_pre", 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_q("rst_async", 1'b0);
        edge_then_sample();
        check_q("rst_held", 1'b0);
        @(negedge ph1);
        reset = 1'b1;
        edge_then_sample();
        check_q("rst_release", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
